// File: rtl/tc_sram_pwrctrl.sv
// Multi-port behavioural SRAM with a power-state controller (ACTIVE / ENTER / RET / OFF / WAKE).
// Latency: 1-cycle registered read; gnt_o combinational; RET/OFF entry SleepCycles+1, wake WakeCycles+1.
// Backpressure: requests are granted only in ACTIVE; ungranted requests are dropped, not queued.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i per-port access request, write enable, word address, data, byte enables
//   gnt_o                         per-port grant (req_i && state == ACTIVE)
//   rdata_o                       per-port registered read data, held when no granted read
//   pwr_req_i/pwr_mode_i          power-mode change request and target (00 ACT, 01 RET, 10 OFF, 11 no-op)
//   pwr_ack_o                     one-cycle pulse when the target mode is reached
//   pwr_state_o                   FSM state encoding
//   deepsleep_o/powergate_o       retention / power-gate indicators
module tc_sram_pwrctrl #(
    parameter int unsigned          NumWords    = 1024,
    parameter int unsigned          DataWidth   = 64,
    parameter int unsigned          ByteWidth   = 8,
    parameter int unsigned          NumPorts    = 2,
    parameter int unsigned          SleepCycles = 4,
    parameter int unsigned          WakeCycles  = 8,
    parameter logic [DataWidth-1:0] OffFill     = '1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned MaxCycles = (SleepCycles > WakeCycles) ? SleepCycles : WakeCycles,
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            req_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts*AddrWidth-1:0]  addr_i,
    input  logic [NumPorts*DataWidth-1:0]  wdata_i,
    input  logic [NumPorts*BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]            gnt_o,
    output logic [NumPorts*DataWidth-1:0]  rdata_o,
    input  logic                           pwr_req_i,
    input  logic [1:0]                     pwr_mode_i,
    output logic                           pwr_ack_o,
    output logic [2:0]                     pwr_state_o,
    output logic                           deepsleep_o,
    output logic                           powergate_o
);

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_ENTER  = 3'd1,
        ST_RET    = 3'd2,
        ST_OFF    = 3'd3,
        ST_WAKE   = 3'd4
    } state_e;

    localparam logic [CntWidth-1:0] SleepLoad = CntWidth'(SleepCycles - 1);
    localparam logic [CntWidth-1:0] WakeLoad  = CntWidth'(WakeCycles - 1);

    // ------------------------------------------------------------------
    // Power FSM state
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    state_e                target_q, target_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  ack_q, ack_d;

    state_e                mode_tgt;
    logic                  mode_valid;
    logic                  stable;
    logic                  active;
    logic                  fill_off;

    // ------------------------------------------------------------------
    // Array and per-port unpacked views
    // ------------------------------------------------------------------
    logic [DataWidth-1:0]  mem_q   [NumWords];
    logic [DataWidth-1:0]  rdata_q [NumPorts];

    logic [AddrWidth-1:0]  port_addr  [NumPorts];
    logic [DataWidth-1:0]  port_wdata [NumPorts];
    logic [BeWidth-1:0]    port_be    [NumPorts];
    logic [DataWidth-1:0]  port_mask  [NumPorts];
    logic [NumPorts-1:0]   port_hit;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            port_addr[p]  = addr_i[p*AddrWidth +: AddrWidth];
            port_wdata[p] = wdata_i[p*DataWidth +: DataWidth];
            port_be[p]    = be_i[p*BeWidth +: BeWidth];
            port_mask[p]  = '0;
            for (int i = 0; i < DataWidth; i++) begin
                port_mask[p][i] = port_be[p][i / ByteWidth];
            end
            // Non-power-of-two arrays leave a hole at the top of the address space.
            port_hit[p] = (32'(port_addr[p]) < NumWords);
        end
    end

    // ------------------------------------------------------------------
    // Mode decode
    // ------------------------------------------------------------------
    always_comb begin
        mode_tgt   = ST_ACTIVE;
        mode_valid = 1'b1;
        unique case (pwr_mode_i)
            2'b00:   mode_tgt = ST_ACTIVE;
            2'b01:   mode_tgt = ST_RET;
            2'b10:   mode_tgt = ST_OFF;
            default: mode_valid = 1'b0;
        endcase
    end

    assign stable = (state_q == ST_ACTIVE) || (state_q == ST_RET) || (state_q == ST_OFF);
    assign active = (state_q == ST_ACTIVE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;

        unique case (state_q)
            ST_ACTIVE, ST_RET, ST_OFF: begin
                // The requester still holds pwr_req_i during the ack cycle; skip
                // sampling then so one request never yields a second ack.
                if (pwr_req_i && !ack_q) begin
                    if (!mode_valid || (mode_tgt == state_q)) begin
                        ack_d = 1'b1;
                    end else if (mode_tgt == ST_ACTIVE) begin
                        state_d = ST_WAKE;
                        cnt_d   = WakeLoad;
                    end else begin
                        state_d  = ST_ENTER;
                        target_d = mode_tgt;
                        cnt_d    = SleepLoad;
                    end
                end
            end
            ST_ENTER: begin
                if (cnt_q == '0) begin
                    state_d = target_q;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // The array is wiped on the same edge the FSM lands in OFF.
    assign fill_off = (state_q == ST_ENTER) && (state_d == ST_OFF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_ACTIVE;
            target_q <= ST_ACTIVE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Access grant
    // ------------------------------------------------------------------
    assign gnt_o = req_i & {NumPorts{active}};

    // ------------------------------------------------------------------
    // Array writes. Ports are walked in ascending order with bit-level
    // non-blocking updates, so on a same-address collision the higher port
    // wins only on the lanes it actually enables.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWords; w++) begin
                mem_q[w] <= OffFill;
            end
        end else if (fill_off) begin
            for (int w = 0; w < NumWords; w++) begin
                mem_q[w] <= OffFill;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (gnt_o[p] && we_i[p] && port_hit[p]) begin
                    for (int i = 0; i < DataWidth; i++) begin
                        if (port_mask[p][i]) begin
                            mem_q[port_addr[p]][i] <= port_wdata[p][i];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data: samples the pre-write array contents, so a read racing a
    // write to the same word returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) begin
                rdata_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (gnt_o[p] && !we_i[p]) begin
                    rdata_q[p] <= port_hit[p] ? mem_q[port_addr[p]] : '0;
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            rdata_o[p*DataWidth +: DataWidth] = rdata_q[p];
        end
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign pwr_ack_o   = ack_q;
    assign pwr_state_o = state_q;
    assign deepsleep_o = (state_q == ST_RET) || ((state_q == ST_ENTER) && (target_q == ST_RET));
    assign powergate_o = (state_q == ST_OFF) || ((state_q == ST_ENTER) && (target_q == ST_OFF));

endmodule

// File: tb/tb_tc_sram_pwrctrl.sv
module tb_tc_sram_pwrctrl;

    localparam int NP = 2;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int NW = 1024;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NP-1:0]     req_i;
    logic [NP-1:0]     we_i;
    logic [NP*AW-1:0]  addr_i;
    logic [NP*DW-1:0]  wdata_i;
    logic [NP*BW-1:0]  be_i;
    logic [NP-1:0]     gnt_o;
    logic [NP*DW-1:0]  rdata_o;
    logic              pwr_req_i;
    logic [1:0]        pwr_mode_i;
    logic              pwr_ack_o;
    logic [2:0]        pwr_state_o;
    logic              deepsleep_o;
    logic              powergate_o;

    tc_sram_pwrctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .rdata_o     (rdata_o),
        .pwr_req_i   (pwr_req_i),
        .pwr_mode_i  (pwr_mode_i),
        .pwr_ack_o   (pwr_ack_o),
        .pwr_state_o (pwr_state_o),
        .deepsleep_o (deepsleep_o),
        .powergate_o (powergate_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int          port;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [NW];
    logic [63:0] last_rd [NP];

    task automatic model_fill();
        for (int i = 0; i < NW; i++) model[i] = '1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One access cycle on both ports. Expected read data (or the held value
    // for an ungranted port) is queued before the edge, writes then update
    // the model in port order, and results are popped after the edge.
    task automatic access_cycle(input string name, input logic [1:0] rq, input logic [1:0] wr,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic exp_active);
        logic [1:0]  eg;
        logic [9:0]  aa [NP];
        logic [63:0] dd [NP];
        logic [7:0]  bb [NP];
        exp_t        e;
        aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1; bb[0] = b0; bb[1] = b1;
        req_i = rq; we_i = wr; addr_i = {a1, a0}; wdata_i = {d1, d0}; be_i = {b1, b0};
        #1;
        eg = exp_active ? rq : 2'b00;
        tests_run++;
        if (gnt_o !== eg) begin
            tests_failed++;
            $display("FAIL %s gnt: got %b expected %b", name, gnt_o, eg);
        end
        for (int p = 0; p < NP; p++) begin
            e.port = p;
            e.data = (eg[p] && !wr[p]) ? model[aa[p]] : last_rd[p];
            sb.push_back(e);
        end
        for (int p = 0; p < NP; p++) begin
            if (eg[p] && wr[p]) begin
                for (int i = 0; i < DW; i++) if (bb[p][i/8]) model[aa[p]][i] = dd[p][i];
            end
        end
        step();
        req_i = '0; we_i = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            last_rd[e.port] = e.data;
            tests_run++;
            if (rdata_o[e.port*DW +: DW] !== e.data) begin
                tests_failed++;
                $display("FAIL %s rdata[%0d]: got %h expected %h", name, e.port,
                         rdata_o[e.port*DW +: DW], e.data);
            end
        end
    endtask

    task automatic pwr_change(input string name, input logic [1:0] mode, input int exp_lat,
                              input logic [2:0] exp_state, input logic [2:0] exp_mid,
                              input logic exp_ds, input logic exp_pg);
        int n;
        bit got;
        n = 0; got = 0;
        pwr_mode_i = mode; pwr_req_i = 1'b1;
        while (n < 40 && !got) begin
            step();
            n++;
            if (n == 1 && exp_lat > 1) begin
                tests_run++;
                if (pwr_state_o !== exp_mid || deepsleep_o !== exp_ds || powergate_o !== exp_pg ||
                    pwr_ack_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s mid: state %0d ds %b pg %b ack %b expected %0d %b %b 0", name,
                             pwr_state_o, deepsleep_o, powergate_o, pwr_ack_o, exp_mid, exp_ds, exp_pg);
                end
            end
            if (pwr_ack_o === 1'b1) got = 1;
        end
        pwr_req_i = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s ack timeout: no ack after %0d cycles expected %0d", name, n, exp_lat);
        end else if (n != exp_lat || pwr_state_o !== exp_state || deepsleep_o !== exp_ds ||
                     powergate_o !== exp_pg) begin
            tests_failed++;
            $display("FAIL %s ack: lat %0d state %0d ds %b pg %b expected %0d %0d %b %b", name, n,
                     pwr_state_o, deepsleep_o, powergate_o, exp_lat, exp_state, exp_ds, exp_pg);
        end
        step();
        tests_run++;
        if (pwr_ack_o !== 1'b0 || pwr_state_o !== exp_state) begin
            tests_failed++;
            $display("FAIL %s post-ack: ack %b state %0d expected 0 %0d", name, pwr_ack_o,
                     pwr_state_o, exp_state);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
        pwr_req_i = 1'b0; pwr_mode_i = 2'b00;
        #3;
        tests_run++;
        if (gnt_o !== 2'b00 || rdata_o !== '0 || pwr_ack_o !== 1'b0 || pwr_state_o !== 3'd0 ||
            deepsleep_o !== 1'b0 || powergate_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: gnt %b rdata %h ack %b state %0d ds %b pg %b expected all zero",
                     gnt_o, rdata_o, pwr_ack_o, pwr_state_o, deepsleep_o, powergate_o);
        end
        step(); step();
        rst_ni = 1'b1;
        model_fill();
        for (int p = 0; p < NP; p++) last_rd[p] = '0;
        step();
    endtask

    task automatic test_byte_enable();
        access_cycle("be_write", 2'b01, 2'b01, 10'd5, 10'd0, 64'h1122334455667788, 64'h0, 8'h0F, 8'h00, 1'b1);
        access_cycle("be_read", 2'b11, 2'b00, 10'd5, 10'd5, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
        tests_run++;
        if (rdata_o[63:0] !== 64'hFFFFFFFF55667788) begin
            tests_failed++;
            $display("FAIL be_const: got %h expected ffffffff55667788", rdata_o[63:0]);
        end
    endtask

    task automatic test_retention();
        access_cycle("ret_write", 2'b01, 2'b01, 10'd3, 10'd0, 64'hA5, 64'h0, 8'hFF, 8'h00, 1'b1);
        pwr_change("to_ret", 2'b01, 5, 3'd2, 3'd1, 1'b1, 1'b0);
        access_cycle("ret_blocked", 2'b11, 2'b10, 10'd3, 10'd3, 64'h0, 64'h77, 8'h00, 8'hFF, 1'b0);
        pwr_change("ret_wake", 2'b00, 9, 3'd0, 3'd4, 1'b0, 1'b0);
        access_cycle("ret_read", 2'b10, 2'b00, 10'd0, 10'd3, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_off();
        access_cycle("off_preread", 2'b01, 2'b00, 10'd3, 10'd0, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
        pwr_change("to_off", 2'b10, 5, 3'd3, 3'd1, 1'b0, 1'b1);
        model_fill();
        access_cycle("off_blocked", 2'b01, 2'b00, 10'd3, 10'd0, 64'h0, 64'h0, 8'h00, 8'h00, 1'b0);
        pwr_change("off_to_ret", 2'b01, 5, 3'd2, 3'd1, 1'b1, 1'b0);
        pwr_change("off_wake", 2'b00, 9, 3'd0, 3'd4, 1'b0, 1'b0);
        access_cycle("off_read", 2'b11, 2'b00, 10'd3, 10'd5, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_collision();
        access_cycle("col_write", 2'b11, 2'b11, 10'd7, 10'd7, 64'h1, 64'h2, 8'hFF, 8'hFF, 1'b1);
        access_cycle("col_read", 2'b01, 2'b00, 10'd7, 10'd0, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
        access_cycle("rw_same", 2'b11, 2'b10, 10'd7, 10'd7, 64'h0, 64'h3, 8'h00, 8'hFF, 1'b1);
        access_cycle("rw_after", 2'b10, 2'b00, 10'd0, 10'd7, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
        access_cycle("col_partial", 2'b11, 2'b11, 10'd8, 10'd8, 64'hAAAAAAAAAAAAAAAA,
                     64'h5555555555555555, 8'hFF, 8'h0F, 1'b1);
        access_cycle("col_part_rd", 2'b11, 2'b00, 10'd8, 10'd8, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_same_mode();
        pwr_change("same_active", 2'b00, 1, 3'd0, 3'd0, 1'b0, 1'b0);
        pwr_change("reserved", 2'b11, 1, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_pwr_ignore();
        int acks;
        acks = 0;
        pwr_mode_i = 2'b01; pwr_req_i = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (pwr_ack_o === 1'b1) begin
                acks++;
                pwr_req_i = 1'b0;
            end
            if (k == 0) pwr_req_i = 1'b0;
            if (k == 1) begin pwr_req_i = 1'b1; pwr_mode_i = 2'b10; end
            if (k == 2) pwr_mode_i = 2'b01;
        end
        pwr_req_i = 1'b0;
        tests_run++;
        if (acks != 1 || pwr_state_o !== 3'd2 || deepsleep_o !== 1'b1 || powergate_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_enter: acks %0d state %0d ds %b pg %b expected 1 2 1 0", acks,
                     pwr_state_o, deepsleep_o, powergate_o);
        end
        pwr_change("ignore_wake", 2'b00, 9, 3'd0, 3'd4, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wake();
        int acks;
        acks = 0;
        access_cycle("rst_write", 2'b01, 2'b01, 10'd3, 10'd0, 64'hA5, 64'h0, 8'hFF, 8'h00, 1'b1);
        access_cycle("rst_preread", 2'b01, 2'b00, 10'd3, 10'd0, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
        pwr_change("rst_to_ret", 2'b01, 5, 3'd2, 3'd1, 1'b1, 1'b0);
        pwr_mode_i = 2'b00; pwr_req_i = 1'b1;
        step(); step(); step();
        tests_run++;
        if (pwr_state_o !== 3'd4) begin
            tests_failed++;
            $display("FAIL rst_in_wake: state %0d expected 4", pwr_state_o);
        end
        rst_ni = 1'b0;
        pwr_req_i = 1'b0;
        #1;
        tests_run++;
        if (pwr_state_o !== 3'd0 || pwr_ack_o !== 1'b0 || rdata_o !== '0 || deepsleep_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: state %0d ack %b rdata %h ds %b expected 0 0 0 0",
                     pwr_state_o, pwr_ack_o, rdata_o, deepsleep_o);
        end
        step();
        rst_ni = 1'b1;
        for (int p = 0; p < NP; p++) last_rd[p] = '0;
        model_fill();
        for (int k = 0; k < 12; k++) begin
            step();
            if (pwr_ack_o === 1'b1) acks++;
        end
        tests_run++;
        if (acks != 0 || pwr_state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_no_ack: acks %0d state %0d expected 0 0", acks, pwr_state_o);
        end
        access_cycle("rst_read", 2'b01, 2'b00, 10'd3, 10'd0, 64'h0, 64'h0, 8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_retention();
        test_off();
        test_collision();
        test_same_mode();
        test_pwr_ignore();
        test_reset_mid_wake();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
